// File: rtl/light_decoder_if.sv
// Light decoder signal bundle: the raw light input and the classified mode outputs.
interface light_decoder_if;
    logic       led;
    logic [1:0] mode;
    logic       valid;
    logic       changed;
    logic       err;

    modport master (
        output led,
        input  mode,
        input  valid,
        input  changed,
        input  err
    );

    modport slave (
        input  led,
        output mode,
        output valid,
        output changed,
        output err
    );
endinterface

// File: rtl/light_decoder.sv
// Light decoder: synchronizes an asynchronous light signal, measures high time and
// rising edges over fixed windows, classifies each window as OFF/ON/BLINK/DIM and
// only reports a mode after it has been seen in CONFIRM consecutive windows.
module light_decoder #(
    parameter int W       = 16,
    parameter int TOL     = 1,
    parameter int CONFIRM = 2
) (
    input logic            clk,
    input logic            rst_n,
    light_decoder_if.slave bus
);
    localparam int IW     = $clog2(W);
    localparam int CW     = $clog2(CONFIRM + 1);
    localparam int HALF   = W / 2;
    localparam int THREEQ = (3 * W) / 4;
    localparam int EIGHTH = W / 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_DIM   = 2'b11
    } mode_t;

    logic          sync_a;
    logic          sync_b;
    logic          s;
    logic [IW-1:0] idx;
    logic          last;
    logic [IW:0]   h_cnt;
    logic [IW:0]   r_cnt;
    logic [IW:0]   h_full;
    logic [IW:0]   r_full;
    logic          prev_s;
    int            h_val;
    int            r_val;
    mode_t         cls;
    logic          cls_ok;
    mode_t         cand;
    mode_t         cand_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    mode_t         mode_q;
    logic          valid_q;
    logic          changed_q;
    logic          err_q;

    assign s    = sync_b;
    assign last = (idx == IW'(W - 1));

    // Counts including the sample taken this cycle, so the last sample of a window is classified.
    assign h_full = h_cnt + (IW + 1)'(s);
    assign r_full = r_cnt + (IW + 1)'(s & ~prev_s);
    assign h_val  = int'(h_full);
    assign r_val  = int'(r_full);

    // Two-flop synchronizer for the asynchronous light input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= bus.led;
            sync_b <= sync_a;
        end
    end

    // Free-running window index plus per-window high and rising-edge counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            h_cnt  <= '0;
            r_cnt  <= '0;
            prev_s <= 1'b0;
        end else begin
            idx    <= idx + 1'b1;
            prev_s <= s;
            if (last) begin
                h_cnt <= '0;
                r_cnt <= '0;
            end else begin
                h_cnt <= h_full;
                r_cnt <= r_full;
            end
        end
    end

    // Classify the completed window by high count and edge count, in priority order.
    always_comb begin
        cls    = MODE_OFF;
        cls_ok = 1'b1;
        if (h_val == 0) begin
            cls = MODE_OFF;
        end else if (h_val == W) begin
            cls = MODE_ON;
        end else if ((h_val >= HALF - TOL) && (h_val <= HALF + TOL) && (r_val <= 2)) begin
            cls = MODE_BLINK;
        end else if ((h_val >= THREEQ - TOL) && (h_val <= THREEQ + TOL) && (r_val >= EIGHTH)) begin
            cls = MODE_DIM;
        end else begin
            cls_ok = 1'b0;
        end
    end

    // Candidate tracking: repeat of the candidate counts up (saturating), a new class restarts at one.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (cls == cand) begin
            if (int'(cnt) < CONFIRM) begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cand_next = cls;
            cnt_next  = CW'(1);
        end
    end

    // At each window end, update confirmation state and publish confirmed mode and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand      <= MODE_OFF;
            cnt       <= '0;
            mode_q    <= MODE_OFF;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            if (last) begin
                if (cls_ok) begin
                    cand <= cand_next;
                    cnt  <= cnt_next;
                    if (int'(cnt_next) == CONFIRM) begin
                        mode_q    <= cand_next;
                        valid_q   <= 1'b1;
                        changed_q <= !valid_q || (mode_q != cand_next);
                    end
                end else begin
                    err_q <= 1'b1;
                    cnt   <= '0;
                end
            end
        end
    end

    assign bus.mode    = mode_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_light_decoder.sv
// Testbench for light_decoder: directed and random light patterns feed a window-level
// reference model; expected per-window results go into a scoreboard queue that a
// separate monitor drains and compares against the outputs.
module tb_light_decoder;
    localparam int W       = 16;
    localparam int TOL     = 1;
    localparam int CONFIRM = 2;

    typedef struct {
        int       cyc;
        bit [1:0] mode;
        bit       valid;
        bit       changed;
        bit       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    light_decoder_if dut_if ();

    light_decoder #(.W(W), .TOL(TOL), .CONFIRM(CONFIRM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dut_if)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   hist[$];
    int   k_stim = 0;
    int   cyc = 0;
    int   seen_changed = 0;
    int   seen_err = 0;

    // Reference model state
    int   m_cand = 0;
    int   m_cnt = 0;
    int   m_mode = 0;
    bit   m_valid = 1'b0;

    // Monitor's view of what mode/valid should be holding between window ends
    int   hold_mode = 0;
    bit   hold_valid = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Synchronized sample seen by the classifier on post-reset clock edge j.
    function automatic bit sampleAt(input int j);
        if (j < 2) return 1'b0;
        return hist[j - 2];
    endfunction

    // -1 means the window cannot be classified.
    function automatic int classify(input int h, input int r);
        int dh;
        int dd;
        dh = (h > W / 2) ? h - W / 2 : W / 2 - h;
        dd = (h > 3 * W / 4) ? h - 3 * W / 4 : 3 * W / 4 - h;
        if (h == 0) return 0;
        if (h == W) return 1;
        if (dh <= TOL && r <= 2) return 2;
        if (dd <= TOL && r >= W / 8) return 3;
        return -1;
    endfunction

    // Window k-W+1..k has just completed: derive H/R from the raw history and apply the confirm rules.
    task automatic evalWindow(input int k);
        int   start;
        int   h;
        int   r;
        int   c;
        bit   prev;
        bit   sv;
        exp_t e;
        start = k - W + 1;
        h = 0;
        r = 0;
        prev = (start >= 1) ? sampleAt(start - 1) : 1'b0;
        for (int j = start; j <= k; j++) begin
            sv = sampleAt(j);
            h += int'(sv);
            if (sv && !prev) r++;
            prev = sv;
        end
        c = classify(h, r);
        e.changed = 1'b0;
        e.err = 1'b0;
        if (c < 0) begin
            e.err = 1'b1;
            m_cnt = 0;
        end else begin
            if (c == m_cand) begin
                if (m_cnt < CONFIRM) m_cnt++;
            end else begin
                m_cand = c;
                m_cnt = 1;
            end
            if (m_cnt == CONFIRM) begin
                if (!m_valid || m_mode != m_cand) e.changed = 1'b1;
                m_mode = m_cand;
                m_valid = 1'b1;
            end
        end
        e.cyc = k;
        e.mode = 2'(m_mode);
        e.valid = m_valid;
        sb.push_back(e);
    endtask

    function automatic bit patBit(input int kind, input int t);
        case (kind)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((t % 16) < 8);
            3: return ((t % 4) != 3);
            4: return ((t % 16) < 5);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Drive one pattern for a number of cycles, feeding the model after every clock edge.
    task automatic applyStimulus(input int kind, input int phase, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            dut_if.led = patBit(kind, i + phase);
            hist.push_back(dut_if.led);
            @(posedge clk);
            if ((k_stim % W) == W - 1) evalWindow(k_stim);
            k_stim++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_mode", int'(dut_if.mode), 0);
        checkOutput("rst_valid", int'(dut_if.valid), 0);
        checkOutput("rst_changed", int'(dut_if.changed), 0);
        checkOutput("rst_err", int'(dut_if.err), 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetState();
        hist.delete();
        k_stim = 0;
        m_cand = 0;
        m_cnt = 0;
        m_mode = 0;
        m_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Post-reset clock edge counter used by the monitor to line up scoreboard entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: at window ends pop and compare the scoreboard, otherwise require held outputs and no pulses.
    always @(negedge clk) begin : monitor
        int   k;
        exp_t e;
        if (!rst_n) begin
            hold_mode = 0;
            hold_valid = 1'b0;
        end else if (cyc > 0) begin
            k = cyc - 1;
            if (dut_if.changed === 1'b1) seen_changed++;
            if (dut_if.err === 1'b1) seen_err++;
            if (sb.size() > 0 && sb[0].cyc < k) begin
                checkOutput("sb_late_entry", sb[0].cyc, k);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checkOutput("win_mode", int'(dut_if.mode), int'(e.mode));
                checkOutput("win_valid", int'(dut_if.valid), int'(e.valid));
                checkOutput("win_changed", int'(dut_if.changed), int'(e.changed));
                checkOutput("win_err", int'(dut_if.err), int'(e.err));
                hold_mode = int'(e.mode);
                hold_valid = e.valid;
            end else begin
                checkOutput("idle_changed", int'(dut_if.changed), 0);
                checkOutput("idle_err", int'(dut_if.err), 0);
                checkOutput("idle_mode", int'(dut_if.mode), hold_mode);
                checkOutput("idle_valid", int'(dut_if.valid), int'(hold_valid));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int c0;
        int e0;
        dut_if.led = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkResetState();
        rst_n = 1'b1;

        // Constant dark: OFF confirmed once, never an error
        c0 = seen_changed;
        e0 = seen_err;
        applyStimulus(0, 0, 3 * W);
        checkOutput("off_changed_count", seen_changed - c0, 1);
        checkOutput("off_err_count", seen_err - e0, 0);
        checkOutput("off_mode", int'(dut_if.mode), 0);
        checkOutput("off_valid", int'(dut_if.valid), 1);

        // Constant lit, then square-wave blink at a random phase
        applyStimulus(1, 0, 3 * W);
        applyStimulus(2, int'($urandom_range(0, 15)), 3 * W);

        // DIM, then back to dark: one mixed window, then OFF confirmed with one changed pulse
        applyStimulus(3, 0, 3 * W);
        checkOutput("dim_mode", int'(dut_if.mode), 3);
        c0 = seen_changed;
        applyStimulus(0, 0, 4 * W);
        checkOutput("dim_to_off_changed_count", seen_changed - c0, 1);
        checkOutput("dim_to_off_mode", int'(dut_if.mode), 0);

        // DIM confirmed, then an unclassifiable duty cycle: error every window, mode holds
        applyStimulus(3, 0, 3 * W);
        c0 = seen_changed;
        e0 = seen_err;
        applyStimulus(4, 0, 3 * W);
        checkOutput("bad_err_count", seen_err - e0, 3);
        checkOutput("bad_changed_count", seen_changed - c0, 0);
        checkOutput("bad_mode_hold", int'(dut_if.mode), 3);
        checkOutput("bad_valid_hold", int'(dut_if.valid), 1);
        applyStimulus(3, 0, W);

        // BLINK confirmed, reset mid-window at index 7, then BLINK re-confirmed
        applyStimulus(2, 0, 3 * W);
        applyStimulus(2, 0, 7);
        doReset();
        applyStimulus(2, 0, 3 * W);
        checkOutput("blink_after_reset_mode", int'(dut_if.mode), 2);
        checkOutput("blink_after_reset_valid", int'(dut_if.valid), 1);

        // Random mix of patterns, phases and segment lengths
        for (int n = 0; n < 12; n++) begin
            applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                          W * int'($urandom_range(1, 3)));
        end

        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/light_decoder.md
LIGHT_DECODER -- requirements
Module: light_decoder

Interface
REQ-001 Parameter W, default 16: observation window length in clock cycles; SHALL be a power of two, at least 8.
REQ-002 Parameter TOL, default 1: allowed deviation of the high-sample count from its nominal value.
REQ-003 Parameter CONFIRM, default 2: number of consecutive identical classifications required before the mode output updates; SHALL be at least 1.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 led  input  1  asynchronous light signal to be classified.
REQ-007 mode  output  2  confirmed light mode: 00 OFF, 01 ON, 10 BLINK, 11 DIM.
REQ-008 valid  output  1  high once at least one mode has been confirmed since reset.
REQ-009 changed  output  1  one-cycle pulse when mode or valid updates to a new value.
REQ-010 err  output  1  one-cycle pulse when a window cannot be classified.

Function
REQ-011 led SHALL pass through a 2-flop synchronizer; only the synchronized bit s is used by the classifier.
REQ-012 A window index SHALL count 0..W-1 and then wrap to 0, free-running from reset release; each window samples s exactly W times.
REQ-013 Per window: H = number of cycles with s=1, range 0..W, width log2(W)+1; R = number of 0->1 transitions of s; the first sample is compared with the last sample of the previous window (0 after reset).
REQ-014 Classification SHALL use H and R after the final sample (index W-1) is included, with this priority: H=0 -> OFF; H=W -> ON; |H-W/2|<=TOL and R<=2 -> BLINK; |H-3W/4|<=TOL and R>=W/8 -> DIM; otherwise unclassified.
REQ-015 H and R SHALL clear at the window boundary, so the next window starts counting with its index-0 sample.
REQ-016 Confirmation state SHALL consist of a candidate mode and a count from 0 to CONFIRM.
REQ-017 Classified window equal to the candidate: count increments, saturating at CONFIRM. Classified window different from the candidate: the class becomes the candidate and count = 1.
REQ-018 Unclassified window: err pulses; count resets to 0; candidate, mode and valid hold.
REQ-019 When the count reaches CONFIRM, the candidate SHALL be copied to mode and valid set to 1. changed pulses only if valid was 0 or mode differs from the candidate.
REQ-020 A saturated count with an unchanged candidate SHALL NOT produce further changed pulses.
REQ-021 mode, valid, changed and err SHALL update on the clock edge that samples index W-1. Latency from a led change to mode update: at most 2 sync cycles + (CONFIRM+1)*W cycles.
REQ-022 changed and err SHALL never both be high in the same cycle.

Reset
REQ-023 While rst_n=0, the block SHALL hold these values: mode=00, valid=0, changed=0, err=0, synchronizer flops=0, window index=0, H=0, R=0, previous sample=0, candidate=00, count=0.
REQ-024 Reset assertion mid-window SHALL discard the partial window; after release, counting restarts at index 0 with no output pulse.

Verification (W=16, TOL=1, CONFIRM=2)
REQ-025 led=0 constant from reset release -> after the second window, mode=00, valid=1, changed pulses once; no err at any time.
REQ-026 led=1 constant -> mode=01 after 2 windows plus sync; changed pulses once; H=16 in each window.
REQ-027 led 8 high / 8 low, period 16, any phase -> H=8 and R<=1 per window; mode=10 after 2 windows.
REQ-028 led repeating 1,1,1,0 -> H=12 and R=4 per window; mode=11 after 2 windows; then switch to led=0 -> mode=00 after 2 more full windows, with changed pulsing exactly once.
REQ-029 led with 5 highs per 16 cycles after DIM is confirmed -> err pulses every window; mode stays 11 with valid=1; count returns to 0; a later single DIM window does not pulse changed.
REQ-030 rst_n pulsed low at window index 7 while BLINK is confirmed -> all outputs clear immediately; BLINK is re-confirmed 2 full windows plus sync after release.
